mem_arbiter: RTL

- Two-requester arbiter for the single-port 128x32 instruction/data memory.
- Shares the memory between the multicycle CPU and an auxiliary master (program loader / debug / display DMA).
- Freezes the CPU through its HALT input, runs a bounded burst of aux accesses, then returns the bus.
- Sits between the CPU, the aux master and the memory instance in the top level; it replaces the direct CPU-to-memory connection.

---
 rtl/mem_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port 128x32 memory between a haltable CPU and an aux master.
// Define MEM_ARB_AUX_WRPROT_EN to block aux writes below PROT_TOP and flag them on aux_err_o.
module mem_arbiter #(
  parameter int         HALT_LAT    = 2,
  parameter int         BURST_MAX   = 4,
  parameter int         CPU_QUANTUM = 8,
  parameter logic [6:0] PROT_TOP    = 7'd32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_cs_i,
  input  logic        cpu_we_i,
  input  logic [6:0]  cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_halt_o,
  input  logic        aux_req_i,
  input  logic        aux_we_i,
  input  logic [6:0]  aux_addr_i,
  input  logic [31:0] aux_wdata_i,
  output logic        aux_gnt_o,
  output logic        aux_rvalid_o,
  output logic [31:0] aux_rdata_o,
  output logic        aux_err_o,
  output logic        mem_cs_o,
  output logic        mem_we_o,
  output logic [6:0]  mem_addr_o,
  inout  wire  [31:0] mem_bus_io
);
`ifdef MEM_ARB_AUX_WRPROT_EN
  localparam logic PROT_EN = 1'b1;
`else
  localparam logic PROT_EN = 1'b0;
`endif
  typedef enum logic [1:0] {S_CPU, S_DRAIN, S_AUX, S_REL} state_e;
  state_e      state_q, state_d;
  logic [7:0]  qnt_q, qnt_d, hcnt_q, hcnt_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic        halt_q, halt_d, rvalid_q, err_q;
  logic [31:0] rdata_q, wdata;
  logic        is_aux, gnt, blk;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_CPU;
      qnt_q    <= 8'(CPU_QUANTUM);
      hcnt_q   <= '0;
      bcnt_q   <= '0;
      halt_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      qnt_q    <= qnt_d;
      hcnt_q   <= hcnt_d;
      bcnt_q   <= bcnt_d;
      halt_q   <= halt_d;
      rvalid_q <= gnt & ~aux_we_i;
      err_q    <= gnt & blk;
      if (gnt && !aux_we_i) rdata_q <= mem_bus_io;
    end
  end
  // Burst exit looks at the post-grant count so the last grant goes straight to RELEASE.
  always_comb begin
    qnt_d  = state_q == S_REL ? 8'(CPU_QUANTUM) : (state_q == S_CPU && qnt_q != 8'd0) ? qnt_q - 8'd1 : qnt_q;
    hcnt_d = state_q == S_DRAIN ? hcnt_q + 8'd1 : 8'd0;
    bcnt_d = state_q == S_REL ? 4'd0 : bcnt_q + {3'b0, gnt};
    state_d = state_q;
    case (state_q)
      S_CPU:   state_d = (aux_req_i && qnt_q == 8'd0) ? S_DRAIN : S_CPU;
      S_DRAIN: state_d = !aux_req_i ? S_REL : (hcnt_q == 8'(HALT_LAT - 1)) ? S_AUX : S_DRAIN;
      S_AUX:   state_d = (!aux_req_i || bcnt_d == 4'(BURST_MAX)) ? S_REL : S_AUX;
      default: state_d = S_CPU;
    endcase
    halt_d = state_d == S_DRAIN || state_d == S_AUX;
  end
  always_comb begin
    is_aux     = state_q == S_AUX;
    gnt        = is_aux & aux_req_i & (bcnt_q < 4'(BURST_MAX));
    blk        = PROT_EN & aux_we_i & (aux_addr_i < PROT_TOP);
    mem_cs_o   = is_aux ? gnt & ~blk : cpu_cs_i;
    mem_we_o   = is_aux ? gnt & ~blk & aux_we_i : cpu_we_i;
    mem_addr_o = is_aux ? aux_addr_i : cpu_addr_i;
    wdata      = is_aux ? aux_wdata_i : cpu_wdata_i;
  end
  assign mem_bus_io   = (mem_cs_o & mem_we_o) ? wdata : 'z;
  assign cpu_rdata_o  = mem_bus_io;
  assign cpu_halt_o   = halt_q;
  assign aux_gnt_o    = gnt;
  assign aux_rvalid_o = rvalid_q;
  assign aux_rdata_o  = rdata_q;
  assign aux_err_o    = err_q;
endmodule
